seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: W, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 op  input  3  operation code: 0 ADD, 1 OR, 2 NOR, 3 MUL, 4 DIV, 5..7 reserved.
REQ-006 a  input  W  operand A, unsigned.
REQ-007 b  input  W  operand B, unsigned.
REQ-008 busy  output  1  high while an iterative op is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  2W  registered result.
REQ-011 c_out  output  1  ADD carry-out, registered.
REQ-012 div_by_zero  output  1  DIV with b==0, registered.

Function
REQ-013 States SHALL be IDLE, BUSY and DONE.
REQ-014 Acceptance: start high on a clk edge while in IDLE or DONE SHALL latch op, a and b into internal registers.
REQ-015 start in BUSY SHALL be ignored; op, a and b changes during BUSY SHALL have no effect.
REQ-016 ADD, OR, NOR and reserved ops: on the acceptance edge, go to DONE and register result, so latency is 1 cycle.
REQ-017 ADD: result[W-1:0] = a+b mod 2^W, result[W] = carry, upper bits 0, c_out = carry.
REQ-018 OR and NOR: bitwise over W bits; upper W bits 0; c_out 0.
REQ-019 Reserved op: result 0, c_out 0, div_by_zero 0; done still pulses.
REQ-020 MUL: shift-add, one partial product per cycle; BUSY for exactly W cycles, done visible after edge k+W (k = acceptance edge); result = full 2W-bit a*b.
REQ-021 DIV: restoring, one quotient bit per cycle; same W-cycle timing; result[W-1:0] = quotient, result[2W-1:W] = remainder.
REQ-022 DIV with b==0: SHALL still take W cycles; quotient all ones, remainder = a, div_by_zero = 1.
REQ-023 div_by_zero and c_out SHALL clear on every acceptance of a new op.
REQ-024 BUSY to DONE transition SHALL occur when the internal iteration counter (W down to 1) reaches 1; counter width clog2(W)+1.
REQ-025 DONE SHALL last exactly 1 cycle and return to IDLE unless start is high, which accepts a new op (back-to-back).
REQ-026 done = (state==DONE); busy = (state==BUSY).
REQ-027 result SHALL hold its value from DONE until the next completion; intermediate MUL/DIV values SHALL NOT appear on result.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE and set busy, done, result, c_out, div_by_zero and the counter to 0, including mid-MUL/DIV.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Package seq_alu_pkg SHALL hold the op-code constants (OP_ADD..OP_DIV) and the state encoding.
REQ-031 One sub-module, alu_addsub (W-bit ripple adder/subtractor with carry/borrow), SHALL be shared by ADD, the MUL accumulate and the DIV trial subtract.

Verification (W=8)
REQ-032 ADD a=200, b=100 -> after 1 cycle: done=1, result=0x012C, c_out=1, busy never high.
REQ-033 MUL a=255, b=255 -> busy for 8 cycles, then done=1, result=0xFE01; start pulsed mid-op is ignored.
REQ-034 DIV a=200, b=7 -> after 8 cycles: result=0x041C (remainder 4, quotient 28), div_by_zero=0.
REQ-035 DIV a=9, b=0 -> after 8 cycles: result=0x09FF, div_by_zero=1; next ADD 1+1 -> div_by_zero=0, result=0x0002.
REQ-036 NOR a=0xF0, b=0x0F issued back-to-back in the DONE cycle of a prior op -> next cycle: result=0x0000, done=1.
REQ-037 rst_n low at cycle 4 of MUL -> busy=0, done=0, result=0 immediately; no done pulse follows.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared constants for the sequential ALU.
//   - op-code constants OP_ADD..OP_DIV (op values 5..7 are reserved)
//   - FSM state encoding ST_IDLE / ST_BUSY / ST_DONE
//   - is_iterative(): true for the multi-cycle ops (MUL, DIV)
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_NOR = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_iterative(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle of the sequential ALU.
//   start, op, a, b          : request side (master drives)
//   busy, done, result,
//   c_out, div_by_zero       : status/result side (slave drives)
//
// Handshake: a request is taken on any rising clk edge where start is high
// and the ALU is not busy (busy == 0). op/a/b must be valid on that edge
// only; they are latched internally. done is a one-cycle pulse marking the
// cycle in which result/c_out/div_by_zero first hold the completed values;
// those stay stable until the next completion. There is no back-pressure
// on the result side.
interface seq_alu_if #(
  parameter int W = 8
);
  logic           start;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           c_out;
  logic           div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, c_out, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, c_out, div_by_zero
  );
endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: W-bit ripple-carry adder/subtractor.
//   x, y : operands
//   sub  : 0 -> s = x + y, 1 -> s = x - y (two's complement, y inverted, cin = 1)
//   s    : W-bit sum/difference
//   co   : carry out; in subtract mode co = 1 means no borrow (x >= y)
module alu_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] cy;
  logic       yb;

  always_comb begin
    cy    = '0;
    s     = '0;
    yb    = 1'b0;
    cy[0] = sub;
    for (int i = 0; i < W; i++) begin
      yb      = y[i] ^ sub;
      s[i]    = x[i] ^ yb ^ cy[i];
      cy[i+1] = (x[i] & yb) | (cy[i] & (x[i] ^ yb));
    end
    co = cy[W];
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle ADD/OR/NOR and W-cycle
// shift-add MUL / restoring DIV.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : seq_alu_if slave (start/op/a/b in, busy/done/result/c_out/
//               div_by_zero out)
//   state_dbg : current FSM state (seq_alu_pkg ST_* encoding)
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_alu_if.slave    bus,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(W) + 1;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2:0]     op_q;
  logic [W-1:0]   hi;    // MUL: upper product half; DIV: partial remainder
  logic [W-1:0]   lo;    // MUL: multiplier / lower product; DIV: dividend -> quotient
  logic [W-1:0]   opnd;  // multiplicand or divisor
  logic [2*W-1:0] result_q;
  logic           c_out_q;
  logic           dbz_q;

  logic [W-1:0]   add_x;
  logic [W-1:0]   add_y;
  logic           add_sub;
  logic [W-1:0]   add_s;
  logic           add_co;
  logic [W-1:0]   hi_n;
  logic [W-1:0]   lo_n;
  logic           accept;

  assign accept = bus.start && (state != ST_BUSY);

  // One adder serves three users: ADD at acceptance, the MUL accumulate
  // and the DIV trial subtract while busy.
  always_comb begin
    add_x   = bus.a;
    add_y   = bus.b;
    add_sub = 1'b0;
    if (state == ST_BUSY) begin
      add_y = opnd;
      if (op_q == OP_DIV) begin
        add_x   = {hi[W-2:0], lo[W-1]};
        add_sub = 1'b1;
      end else begin
        add_x = hi;
      end
    end
  end

  alu_addsub #(.W(W)) u_addsub (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .s   (add_s),
    .co  (add_co)
  );

  // One iteration step. For DIV the shifted partial remainder is W+1 bits;
  // when its dropped top bit (hi[W-1]) is set it exceeds any divisor, so the
  // subtract always succeeds and the W-bit difference is still exact.
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    if (op_q == OP_DIV) begin
      if (hi[W-1] | add_co) begin
        hi_n = add_s;
        lo_n = {lo[W-2:0], 1'b1};
      end else begin
        hi_n = {hi[W-2:0], lo[W-1]};
        lo_n = {lo[W-2:0], 1'b0};
      end
    end else begin
      if (lo[0]) begin
        hi_n = {add_co, add_s[W-1:1]};
        lo_n = {add_s[0], lo[W-1:1]};
      end else begin
        hi_n = {1'b0, hi[W-1:1]};
        lo_n = {hi[0], lo[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.op;
      hi      <= '0;
      lo      <= bus.a;
      opnd    <= bus.b;
      c_out_q <= 1'b0;
      dbz_q   <= 1'b0;
      if (is_iterative(bus.op)) begin
        cnt   <= CW'(W);
        state <= ST_BUSY;
      end else begin
        state <= ST_DONE;
        case (bus.op)
          OP_ADD: begin
            result_q <= {{(W-1){1'b0}}, add_co, add_s};
            c_out_q  <= add_co;
          end
          OP_OR:   result_q <= {{W{1'b0}}, bus.a | bus.b};
          OP_NOR:  result_q <= {{W{1'b0}}, ~(bus.a | bus.b)};
          default: result_q <= '0;
        endcase
      end
    end else if (state == ST_BUSY) begin
      hi <= hi_n;
      lo <= lo_n;
      if (cnt == CW'(1)) begin
        // Only the final step is published; intermediates stay internal.
        state    <= ST_DONE;
        cnt      <= '0;
        result_q <= {hi_n, lo_n};
        dbz_q    <= (op_q == OP_DIV) && (opnd == '0);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end

  assign bus.busy        = (state == ST_BUSY);
  assign bus.done        = (state == ST_DONE);
  assign bus.result      = result_q;
  assign bus.c_out       = c_out_q;
  assign bus.div_by_zero = dbz_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  localparam int W      = 8;
  localparam int BUDGET = 40;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  seq_alu_if #(.W(W)) bus ();

  seq_alu #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        dz;
  } vec_t;

  vec_t vecs[14];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model from the arithmetic definition: {dz, c_out, result}
  function automatic logic [17:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int unsigned ua, ub, r;
    logic c, dz;
    ua = a; ub = b; r = 0; c = 1'b0; dz = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 255); end
      3'd1: r = ua | ub;
      3'd2: r = (~(ua | ub)) & 32'hFF;
      3'd3: r = ua * ub;
      3'd4: begin
        if (ub == 0) begin r = (ua << 8) | 32'hFF; dz = 1'b1; end
        else r = ((ua % ub) << 8) | (ua / ub);
      end
      default: r = 0;
    endcase
    return {dz, c, r[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
  endtask

  // Waits for done from "just after an edge"; returns edges waited and busy samples.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!bus.done && lat < BUDGET) begin
      if (bus.busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] er, input logic ec,
                        input logic edz);
    int lat, bc, elat;
    elat = (op == 3'd3 || op == 3'd4) ? W : 0;
    issue(op, a, b);
    wait_done(lat, bc);
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_cycles"}, bc, elat);
    check({tag, " result"}, bus.result, er);
    check({tag, " c_out"}, bus.c_out, ec);
    check({tag, " div_by_zero"}, bus.div_by_zero, edz);
    step();
    check({tag, " done_pulse"}, bus.done, 0);
    check({tag, " result_hold"}, bus.result, er);
  endtask

  // ---------------- test ----------------
  initial begin
    int lat, bc, dseen;
    logic [17:0] m;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0};
    vecs[1]  = '{3'd3, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0};
    vecs[2]  = '{3'd4, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0};
    vecs[3]  = '{3'd4, 8'd9,   8'd0,   16'h09FF, 1'b0, 1'b1};
    vecs[4]  = '{3'd0, 8'd1,   8'd1,   16'h0002, 1'b0, 1'b0};
    vecs[5]  = '{3'd1, 8'hA5,  8'h0F,  16'h00AF, 1'b0, 1'b0};
    vecs[6]  = '{3'd2, 8'hF0,  8'h0F,  16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{3'd2, 8'h00,  8'h00,  16'h00FF, 1'b0, 1'b0};
    vecs[8]  = '{3'd5, 8'hFF,  8'hFF,  16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{3'd3, 8'd13,  8'd11,  16'h008F, 1'b0, 1'b0};
    vecs[10] = '{3'd4, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0};
    vecs[11] = '{3'd4, 8'd7,   8'd200, 16'h0700, 1'b0, 1'b0};
    vecs[12] = '{3'd0, 8'd255, 8'd255, 16'h01FE, 1'b1, 1'b0};
    vecs[13] = '{3'd7, 8'h12,  8'h34,  16'h0000, 1'b0, 1'b0};

    // ---- reset ----
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset result", bus.result, 0);
    check("reset c_out", bus.c_out, 0);
    check("reset div_by_zero", bus.div_by_zero, 0);
    rst_n = 1'b1;

    // ---- table vectors (first one accepted on first edge after reset) ----
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].c, vecs[i].dz);

    // ---- MUL with start pulsed and inputs changed mid-op ----
    issue(3'd3, 8'd255, 8'd255);
    repeat (3) step();
    check("mul_mid busy", bus.busy, 1);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 8'd1; bus.b = 8'd1;
    step();
    bus.start = 1'b0; bus.op = 3'd4; bus.a = 8'd0; bus.b = 8'd0;
    wait_done(lat, bc);
    check("mul_mid remaining", lat, W - 4);
    check("mul_mid result", bus.result, 16'hFE01);
    step();
    check("mul_mid no_extra_done", bus.done, 0);
    check("mul_mid result_hold", bus.result, 16'hFE01);

    // ---- back-to-back: NOR issued in DONE cycle of DIV by zero ----
    issue(3'd4, 8'd9, 8'd0);
    wait_done(lat, bc);
    check("b2b div latency", lat, W);
    check("b2b div dz", bus.div_by_zero, 1);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 8'hF0; bus.b = 8'h0F;
    step();
    bus.start = 1'b0;
    check("b2b nor done", bus.done, 1);
    check("b2b nor result", bus.result, 16'h0000);
    check("b2b nor dz_cleared", bus.div_by_zero, 0);
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 8'd3; bus.b = 8'd5;
    step();
    bus.start = 1'b0;
    check("b2b mul busy", bus.busy, 1);
    wait_done(lat, bc);
    check("b2b mul result", bus.result, 16'd15);
    step();

    // ---- reset in cycle 4 of MUL ----
    run_op("pre_rst add", 3'd0, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0);
    issue(3'd3, 8'd200, 8'd3);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", bus.busy, 0);
    check("rst_mid done", bus.done, 0);
    check("rst_mid result", bus.result, 0);
    step();
    step();
    rst_n = 1'b1;
    dseen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done || bus.busy) dseen++;
    end
    check("rst_mid no_done_after", dseen, 0);
    check("rst_mid result_after", bus.result, 0);

    // ---- randomized against model ----
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      m   = model(rop, ra, rb);
      run_op($sformatf("rnd%0d op%0d a%0d b%0d", i, rop, ra, rb), rop, ra, rb,
             m[15:0], m[16], m[17]);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
